// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM states, bit-counter
// sizing and the per-transfer configuration captured when a word is accepted.
package spi_pkg;

  // Largest supported word width; the edge counter is sized for it.
  localparam int MAX_DATA_W = 32;
  // Counts up to 2*DATA_W sck edges per word.
  localparam int BIT_CNT_W  = $clog2(2 * MAX_DATA_W) + 1;
  // Storage widths of the latched divider and chip-select index.
  // Inputs are zero-extended into these fields on accept.
  localparam int CFG_DIV_W  = 32;
  localparam int CFG_CS_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } spi_state_e;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
    logic [CFG_CS_W-1:0]  cs_sel;
    logic                 keep_cs;
  } spi_cfg_t;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the SPI master. Counts H = div+1 clk cycles per
// half-period while a transfer is active and marks leading/trailing sck edges.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sck_en,
  input  logic [CFG_DIV_W-1:0] div,
  output logic                 tick,
  output logic                 lead_edge,
  output logic                 trail_edge
);

  // One bit wider than div so H = 2^DIV_W is reachable without wrap.
  logic [DIV_W:0] cnt;
  logic           phase;

  assign tick       = en && (CFG_DIV_W'(cnt) == div);
  assign lead_edge  = tick && sck_en && !phase;
  assign trail_edge = tick && sck_en &&  phase;

  // Half-period counter and leading/trailing phase; both park at 0 when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + (DIV_W + 1)'(1);
      if (lead_edge || trail_edge) phase <= ~phase;
    end
  end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: word width, runtime sck divider, CPOL/CPHA,
// bit order and multiple chip selects with optional hold across words.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 1,
  parameter int CS_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              keep_cs,
  output logic              done,
  output logic              rx_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam logic [BIT_CNT_W-1:0] LAST_EDGE = BIT_CNT_W'(2 * DATA_W);
  localparam logic [BIT_CNT_W-1:0] PRE_LAST  = BIT_CNT_W'(2 * DATA_W - 1);

  spi_state_e           state;
  spi_cfg_t             cfg;
  logic [DATA_W-1:0]    tx_sh;
  logic [DATA_W-1:0]    rx_sh;
  logic [BIT_CNT_W-1:0] edge_cnt;
  logic                 busy;
  logic                 sck_en;
  logic                 tick;
  logic                 lead_edge;
  logic                 trail_edge;
  logic                 do_sample;
  logic                 do_present;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Out-of-range selects leave every chip select deasserted.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CFG_CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CFG_CS_W'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign busy   = (state != IDLE);
  // sck toggles at the end of LEAD and between SHIFT half-periods, never into TRAIL.
  assign sck_en = (state == LEAD) || ((state == SHIFT) && (edge_cnt != LAST_EDGE));

  // CPHA=0 samples on leading edges and shifts on trailing ones (except the
  // last, so mosi keeps the final bit); CPHA=1 is the mirror image.
  assign do_sample  = cfg.cpha ? trail_edge : lead_edge;
  assign do_present = cfg.cpha ? lead_edge : (trail_edge && (edge_cnt != PRE_LAST));

  spi_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .sck_en    (sck_en),
    .div       (cfg.div),
    .tick      (tick),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge)
  );

  // Transfer FSM with registered pins, shifters and chip-select control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cfg      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      done     <= 1'b1;
      rx_valid <= 1'b0;
      data_out <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sck <= cpol;
          if (wr) begin
            cfg.div       <= CFG_DIV_W'(div);
            cfg.cpol      <= cpol;
            cfg.cpha      <= cpha;
            cfg.lsb_first <= lsb_first;
            cfg.cs_sel    <= CFG_CS_W'(cs_sel);
            cfg.keep_cs   <= keep_cs;
            rx_sh         <= '0;
            edge_cnt      <= '0;
            done          <= 1'b0;
            cs_n          <= cs_decode(CFG_CS_W'(cs_sel));
            if (!cpha) begin
              mosi  <= first_bit(data_in, lsb_first);
              tx_sh <= shift_out(data_in, lsb_first);
            end else begin
              tx_sh <= data_in;
            end
            state <= LEAD;
          end
        end
        LEAD, SHIFT: begin
          if (lead_edge || trail_edge) begin
            sck      <= lead_edge ? ~cfg.cpol : cfg.cpol;
            edge_cnt <= edge_cnt + BIT_CNT_W'(1);
          end
          if (do_sample) rx_sh <= shift_in(rx_sh, miso, cfg.lsb_first);
          if (do_present) begin
            mosi  <= first_bit(tx_sh, cfg.lsb_first);
            tx_sh <= shift_out(tx_sh, cfg.lsb_first);
          end
          if (tick) begin
            if (state == LEAD)               state <= SHIFT;
            else if (edge_cnt == LAST_EDGE)  state <= TRAIL;
          end
        end
        TRAIL: begin
          if (tick) begin
            state    <= IDLE;
            done     <= 1'b1;
            rx_valid <= 1'b1;
            data_out <= rx_sh;
            if (!cfg.keep_cs) cs_n <= '1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised SPI master, the successor to the fixed 8-bit, mode-0 shifter used in the current designs. It adds configurable word width, a runtime SCK divider, all four CPOL/CPHA modes, MSB/LSB-first ordering and multiple chip selects with hold-across-words. It sits between a simple write/done host handshake and external SPI pins, one transfer at a time.

Parameters:
DATA_W, 8, bits per transfer word (2..32)
DIV_W, 8, width of the runtime clock-divider input
NUM_CS, 1, number of active-low chip-select outputs (1..8)
CS_W, 3, width of cs_sel; must be at least clog2(NUM_CS), minimum 1

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
wr  in  1  start request; sampled only while idle
data_in  in  DATA_W  word to transmit; latched on accept
div  in  DIV_W  half-period = div+1 clk cycles; latched on accept
cpol  in  1  SCK idle level; latched on accept
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on accept
lsb_first  in  1  bit order; latched on accept
cs_sel  in  CS_W  chip select index; latched on accept
keep_cs  in  1  hold cs_n asserted after this word; latched on accept
done  out  1  high when idle and a new wr will be accepted
rx_valid  out  1  one-cycle pulse when data_out updates
data_out  out  DATA_W  last received word
sck  out  1  SPI clock, registered
mosi  out  1  SPI data out, registered
miso  in  1  SPI data in; assumed synchronous to sck, no synchroniser
cs_n  out  NUM_CS  chip selects, active low, registered

Behaviour:
- Reset (async, rst_n=0): state IDLE, done=1, rx_valid=0, data_out=0, sck=0, mosi=0, cs_n all 1, internal counters 0.
- States are IDLE, LEAD, SHIFT and TRAIL. Let H = latched div+1.
- IDLE: sck follows the registered cpol input. When wr=1 at edge T, all config and data_in are latched, done drops at T+1, the selected cs_n goes low at T+1, and the state becomes LEAD.
- LEAD: lasts H cycles. For CPHA=0, mosi presents the first bit from T+1.
- SHIFT: 2*DATA_W half-periods of H cycles each. sck toggles at each half-period boundary.
  - CPHA=0: miso is sampled on odd (leading) edges; the next mosi bit is presented on even (trailing) edges.
  - CPHA=1: mosi is presented on leading edges; miso is sampled on trailing edges.
- Bit order: when lsb_first=1, both directions shift LSB first. Otherwise both shift MSB first.
- TRAIL: lasts H cycles with sck at cpol.
  - On exit: if keep_cs=0, all cs_n go to 1; if keep_cs=1, cs_n holds.
  - On exit: data_out is loaded from the receive shifter, rx_valid=1 for exactly one cycle, done=1, state returns to IDLE.
- Total latency from the wr accept edge to done=1 is (2*DATA_W+2)*H cycles.
- wr while busy is ignored, with no queuing. Input changes while busy have no effect.
- Held chip select: if cs_n is held and the next accepted word selects a different cs_sel, the old select deasserts and the new one asserts in the same cycle (T+1). LEAD is always executed.
- cs_sel >= NUM_CS: the transfer runs normally with every cs_n held at 1.
- div = all-ones: H = 2^DIV_W with no overflow. The half-period counter is DIV_W+1 bits wide.
- rst_n asserted mid-transfer: immediate return to reset values. The partial word is discarded and no rx_valid is issued.
- mosi keeps its last driven value while idle.

Decomposition:
- A shared package spi_pkg holds:
  - the state enum (IDLE, LEAD, SHIFT, TRAIL);
  - a localparam for the bit-counter width, clog2(2*DATA_W)+1;
  - a config struct {div, cpol, cpha, lsb_first, cs_sel, keep_cs} latched on accept.
- One natural sub-module is spi_clkgen. It contains the half-period counter and emits one-cycle tick, lead_edge and trail_edge strobes. The top level owns the FSM, the shifters and the cs logic.

Test Plan:
- DATA_W=8, div=0, mode 0, MSB-first, data_in=0xA5, miso looped to mosi -> 8 rising sck edges; mosi sequence 1,0,1,0,0,1,0,1; data_out=0xA5; rx_valid pulse at exactly 18 cycles after accept; cs_n[0] high afterwards.
- Run all four modes with div=3 and miso tied to the pattern 0x3C -> sck idle level equals cpol; in every mode the sample edge falls mid-bit; data_out=0x3C; done is high after 72 cycles.
- lsb_first=1, data_in=0x01 -> mosi is 1 on the first bit only; looped data_out=0x01.
- NUM_CS=4: word 1 with cs_sel=2, keep_cs=1, then word 2 with cs_sel=2, keep_cs=0 -> cs_n=4'b1011 continuously across both words, then 4'b1111.
- wr pulsed during SHIFT with data_in=0xFF -> ignored; the original word completes unchanged; only one rx_valid.
- rst_n pulsed low mid-SHIFT -> cs_n=all 1, sck=0, done=1 asynchronously; no rx_valid; data_out=0.
